grid_io_tile_cfg: RTL

- Parametrised IO grid tile with N_PADS GPIO subtiles.
- A configuration-chain shift register feeds double-buffered per-pad configuration: bits are shifted into a shadow register and applied to the active register only on an explicit commit.
- Per pad, the active configuration selects direction (input/output) and polarity inversion.
- Sits on the fabric perimeter. Chained head-to-tail with neighbouring tiles through ccff_head/ccff_tail, clocked by prog_clk.

---
 rtl/grid_io_tile_cfg.sv | 137 +++++++++++++
 1 files changed

// File: rtl/grid_io_tile_cfg.sv
// IO grid tile: serial configuration chain with a shadow/active double buffer that drives N_PADS GPIO pads.
// Optional per-pad odd parity checking at commit is enabled by defining CFG_PARITY_EN.
module grid_io_tile_cfg #(
  parameter int N_PADS = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              ccff_en,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic              cfg_commit,
  output logic              cfg_done,
  output logic              cfg_active,
  output logic              cfg_err,
  input  logic [N_PADS-1:0] pin_outpad,
  output logic [N_PADS-1:0] pin_inpad,
  inout  wire  [N_PADS-1:0] gfpga_pad_GPIO_PAD
);

`ifdef CFG_PARITY_EN
  localparam int BITS_PER_PAD = 3;
`else
  localparam int BITS_PER_PAD = 2;
`endif
  localparam int CHAIN_LEN = N_PADS * BITS_PER_PAD;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] L_CNT = CNT_W'(CHAIN_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CHAIN_LEN-1:0]   r_sr;
  logic [CNT_W-1:0]       r_count;
  logic [N_PADS-1:0]      r_dir;
  logic [N_PADS-1:0]      r_inv;
  logic                   r_cfg_done;
  logic                   r_cfg_active;
`ifdef CFG_PARITY_EN
  logic                   r_cfg_err;
  logic [N_PADS-1:0]      w_pad_par_ok;
`endif

  logic [CNT_W-1:0]       w_count_inc;
  logic [N_PADS-1:0]      w_sr_dir;
  logic [N_PADS-1:0]      w_sr_inv;
  logic [N_PADS-1:0]      w_pad_out;
  logic                   w_frame_ok;

  assign w_count_inc = (r_count == L_CNT) ? r_count : (r_count + 1'b1);

  genvar gi;
  generate
    for (gi = 0; gi < N_PADS; gi++) begin : g_pad
      assign w_sr_dir[gi]  = r_sr[gi*BITS_PER_PAD];
      assign w_sr_inv[gi]  = r_sr[gi*BITS_PER_PAD+1];
`ifdef CFG_PARITY_EN
      // Odd parity across {dir, inv, parity} of this pad's shadow slice.
      assign w_pad_par_ok[gi] = ^r_sr[gi*BITS_PER_PAD +: BITS_PER_PAD];
`endif
      assign w_pad_out[gi] = pin_outpad[gi] ^ r_inv[gi];
      assign gfpga_pad_GPIO_PAD[gi] = r_dir[gi] ? w_pad_out[gi] : 1'bz;
      assign pin_inpad[gi] = r_dir[gi] ? 1'b0 : (gfpga_pad_GPIO_PAD[gi] ^ r_inv[gi]);
    end
  endgenerate

`ifdef CFG_PARITY_EN
  assign w_frame_ok = &w_pad_par_ok;
  assign cfg_err    = r_cfg_err;
`else
  assign w_frame_ok = 1'b1;
  assign cfg_err    = 1'b0;
`endif

  assign ccff_tail  = r_sr[CHAIN_LEN-1];
  assign cfg_done   = r_cfg_done;
  assign cfg_active = r_cfg_active;

  // The chain shifts regardless of state so downstream tiles always see the stream.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_state      <= ST_IDLE;
      r_sr         <= '0;
      r_count      <= '0;
      r_dir        <= '0;
      r_inv        <= '0;
      r_cfg_done   <= 1'b0;
      r_cfg_active <= 1'b0;
`ifdef CFG_PARITY_EN
      r_cfg_err    <= 1'b0;
`endif
    end else begin
      if (ccff_en) begin
        r_sr <= {r_sr[CHAIN_LEN-2:0], ccff_head};
      end
      case (r_state)
        ST_IDLE, ST_SHIFT: begin
          if (ccff_en) begin
            r_count <= w_count_inc;
            if (w_count_inc == L_CNT) begin
              r_state    <= ST_FULL;
              r_cfg_done <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_FULL: begin
          if (cfg_commit) begin
            // Capture uses the pre-shift shadow even if a shift lands on the same edge.
            r_count    <= '0;
            r_state    <= ST_IDLE;
            r_cfg_done <= 1'b0;
            if (w_frame_ok) begin
              r_dir        <= w_sr_dir;
              r_inv        <= w_sr_inv;
              r_cfg_active <= 1'b1;
`ifdef CFG_PARITY_EN
              r_cfg_err    <= 1'b0;
            end else begin
              r_cfg_err    <= 1'b1;
`endif
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_cfg_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
